// File: rtl/bt656_pattern_gen.sv
// ---------------------------------------------------------------------------
// bt656_pattern_gen
//   625-line BT.656 (PAL, 8-bit 4:2:2) test-pattern source.  Emits EAV/SAV
//   timing reference codes with protection bits, blanking fill and one of
//   four selectable active-video patterns.  Serves as bring-up stimulus and
//   as an on-chip fallback source when no video decoder is fitted.
//
// Ports
//   bt_clock     in   1   27 MHz byte clock
//   reset        in   1   asynchronous, active-high
//   enable       in   1   run request; acted on in IDLE and at frame end
//   pattern_sel  in   2   0 grey, 1 luma ramp, 2 75% bars, 3 checkerboard
//   bt_data      out  8   BT.656 byte stream (registered)
//   frame_start  out  1   one-cycle pulse with the 0xFF of line-1 EAV
//   field        out  1   F bit of the line being output
//   active       out  1   high while bt_data carries active-video samples
//   line_num     out  10  line being output, 1..625
//
// All outputs are registered and mutually aligned: the byte computed for
// counter position n appears on bt_data one cycle after the counter held n.
// ---------------------------------------------------------------------------
module bt656_pattern_gen #(
    parameter int ACTIVE_SAMPLES = 1440,
    parameter int BLANK_SAMPLES  = 280,
    parameter int FRAME_LINES    = 625,
    parameter int BAR_PIXELS     = 90
) (
    input  logic       bt_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic [7:0] bt_data,
    output logic       frame_start,
    output logic       field,
    output logic       active,
    output logic [9:0] line_num
);

    // Horizontal landmarks: EAV at 0..3, blanking, SAV, then active samples.
    localparam logic [10:0] SAV_C    = 11'(BLANK_SAMPLES + 4);
    localparam logic [10:0] SAV1_C   = 11'(BLANK_SAMPLES + 5);
    localparam logic [10:0] SAV2_C   = 11'(BLANK_SAMPLES + 6);
    localparam logic [10:0] SAV3_C   = 11'(BLANK_SAMPLES + 7);
    localparam logic [10:0] ACT_C    = 11'(BLANK_SAMPLES + 8);
    localparam logic [10:0] H_LAST_C = 11'(ACTIVE_SAMPLES + BLANK_SAMPLES + 7);
    localparam logic [9:0]  L_LAST_C = 10'(FRAME_LINES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // XY word of a timing reference code with its Hamming protection bits.
    function automatic logic [7:0] trs_xy(input logic f, input logic v, input logic h);
        trs_xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // 75% colour bar table, {Y, Cb, Cr}, bar 0 (white) .. bar 7 (black).
    function automatic logic [23:0] bar_ycc(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_ycc = {8'd180, 8'd128, 8'd128};
            3'd1:    bar_ycc = {8'd162, 8'd44,  8'd142};
            3'd2:    bar_ycc = {8'd131, 8'd156, 8'd44};
            3'd3:    bar_ycc = {8'd112, 8'd72,  8'd58};
            3'd4:    bar_ycc = {8'd84,  8'd184, 8'd198};
            3'd5:    bar_ycc = {8'd65,  8'd100, 8'd212};
            3'd6:    bar_ycc = {8'd35,  8'd212, 8'd114};
            3'd7:    bar_ycc = {8'd16,  8'd128, 8'd128};
            default: bar_ycc = {8'd16,  8'd128, 8'd128};
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  line_q, line_d;
    logic [1:0]  pat_q, pat_d;
    logic [7:0]  bt_data_q, bt_data_d;
    logic        frame_start_q, frame_start_d;
    logic        field_q, field_d;
    logic        active_q, active_d;
    logic [9:0]  line_num_q, line_num_d;

    logic        f_s;
    logic        v_s;
    logic        run_s;
    logic        frame_top_s;
    logic        act_s;
    logic [7:0]  fill_s;
    logic [10:0] k_s;
    logic [9:0]  pixel_s;
    logic [9:0]  active_line_s;
    logic [2:0]  bar_s;
    logic [8:0]  ramp_sum_s;
    logic [7:0]  y_s;
    logic [7:0]  cb_s;
    logic [7:0]  cr_s;
    logic [23:0] ycc_s;
    logic [7:0]  video_s;
    logic [7:0]  byte_s;

    // Field/vertical-blanking decode and raster position of the current byte.
    always_comb begin
        f_s = (line_q >= 10'd313);
        v_s = (line_q <= 10'd22) ||
              ((line_q >= 10'd311) && (line_q <= 10'd335)) ||
              (line_q >= 10'd624);
        fill_s  = h_cnt_q[0] ? 8'h10 : 8'h80;
        k_s     = h_cnt_q - ACT_C;
        pixel_s = k_s[10:1];
        if (f_s) begin
            active_line_s = line_q - 10'd336;
        end else begin
            active_line_s = line_q - 10'd23;
        end
        act_s       = (!v_s) && (h_cnt_q >= ACT_C);
        run_s       = (state_q == ST_RUN) || enable;
        frame_top_s = run_s && (h_cnt_q == 11'd0) && (line_q == 10'd1);
    end

    // Colour bar index: the highest bar whose left edge the pixel has reached.
    always_comb begin
        bar_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            bar_s = ({22'd0, pixel_s} >= 32'(i * BAR_PIXELS)) ? 3'(i) : bar_s;
        end
    end

    // Active-video sample for the latched pattern; chroma phase picks Cb/Y/Cr/Y.
    always_comb begin
        ramp_sum_s = 9'd16 + {1'b0, pixel_s[9:2]};
        ycc_s      = bar_ycc(bar_s);
        case (pat_q)
            2'd0: begin
                y_s  = 8'h80;
                cb_s = 8'h80;
                cr_s = 8'h80;
            end
            2'd1: begin
                y_s  = (ramp_sum_s > 9'd235) ? 8'd235 : ramp_sum_s[7:0];
                cb_s = 8'h80;
                cr_s = 8'h80;
            end
            2'd2: begin
                y_s  = ycc_s[23:16];
                cb_s = ycc_s[15:8];
                cr_s = ycc_s[7:0];
            end
            2'd3: begin
                y_s  = (pixel_s[4] ^ active_line_s[4]) ? 8'd235 : 8'd16;
                cb_s = 8'h80;
                cr_s = 8'h80;
            end
            default: begin
                y_s  = 8'h80;
                cb_s = 8'h80;
                cr_s = 8'h80;
            end
        endcase
        case (k_s[1:0])
            2'd0:    video_s = cb_s;
            2'd2:    video_s = cr_s;
            default: video_s = y_s;
        endcase
    end

    // Byte for the current counter position: TRS words, blanking fill or video.
    always_comb begin
        if ((h_cnt_q == 11'd0) || (h_cnt_q == SAV_C)) begin
            byte_s = 8'hFF;
        end else if ((h_cnt_q == 11'd1) || (h_cnt_q == 11'd2) ||
                     (h_cnt_q == SAV1_C) || (h_cnt_q == SAV2_C)) begin
            byte_s = 8'h00;
        end else if (h_cnt_q == 11'd3) begin
            byte_s = trs_xy(f_s, v_s, 1'b1);
        end else if (h_cnt_q == SAV3_C) begin
            byte_s = trs_xy(f_s, v_s, 1'b0);
        end else if ((h_cnt_q < ACT_C) || v_s) begin
            byte_s = fill_s;
        end else begin
            byte_s = video_s;
        end
    end

    // Run/idle sequencing, raster counters, pattern latch and output staging.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        line_d        = line_q;
        pat_d         = pat_q;
        bt_data_d     = (bt_data_q == 8'h80) ? 8'h10 : 8'h80;
        frame_start_d = 1'b0;
        field_d       = 1'b0;
        active_d      = 1'b0;
        line_num_d    = line_q;
        if (run_s) begin
            // IDLE with enable set emits line-1 EAV in this very cycle.
            state_d       = ST_RUN;
            bt_data_d     = byte_s;
            frame_start_d = frame_top_s;
            field_d       = f_s;
            active_d      = act_s;
            if (frame_top_s) begin
                pat_d = pattern_sel;
            end else begin
                pat_d = pat_q;
            end
            if (h_cnt_q == H_LAST_C) begin
                h_cnt_d = 11'd0;
                if (line_q == L_LAST_C) begin
                    line_d  = 10'd1;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end else begin
                    line_d = line_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end else begin
            state_d = ST_IDLE;
            h_cnt_d = 11'd0;
            line_d  = 10'd1;
        end
    end

    // State and output registers; reset abandons any line in progress.
    always_ff @(posedge bt_clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= 11'd0;
            line_q        <= 10'd1;
            pat_q         <= 2'd0;
            bt_data_q     <= 8'h80;
            frame_start_q <= 1'b0;
            field_q       <= 1'b0;
            active_q      <= 1'b0;
            line_num_q    <= 10'd1;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            line_q        <= line_d;
            pat_q         <= pat_d;
            bt_data_q     <= bt_data_d;
            frame_start_q <= frame_start_d;
            field_q       <= field_d;
            active_q      <= active_d;
            line_num_q    <= line_num_d;
        end
    end

    assign bt_data     = bt_data_q;
    assign frame_start = frame_start_q;
    assign field       = field_q;
    assign active      = active_q;
    assign line_num    = line_num_q;

endmodule

// File: tb/tb_bt656_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_bt656_pattern_gen
//   Directed bench.  Two full-size generators (bars and ramp) check line 1,
//   line 23 content and a mid-SAV reset.  A shrunken-line generator
//   (8 active / 4 blank bytes) walks whole 625-line frames to check TRS
//   codes, V/F regions, pattern latching, enable handling and IDLE fill.
// ---------------------------------------------------------------------------
module tb_bt656_pattern_gen;

    localparam int LINE_F = 1728;
    localparam int SAV_F  = 284;
    localparam int LINE_S = 20;
    localparam int SAV_S  = 8;
    localparam int ACT_S  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Full-size pair sharing reset/enable
    logic       reset_f, enable_f;
    logic [1:0] pat_a, pat_b;
    logic [7:0] bt_a, bt_b;
    logic       fs_a, fs_b, fld_a, fld_b, act_a, act_b;
    logic [9:0] ln_a, ln_b;

    // Shrunken-line instance
    logic       reset_s, enable_s;
    logic [1:0] pat_s;
    logic [7:0] bt_s;
    logic       fs_s, fld_s, act_s;
    logic [9:0] ln_s;

    bt656_pattern_gen u_full_a (
        .bt_clock(clk), .reset(reset_f), .enable(enable_f), .pattern_sel(pat_a),
        .bt_data(bt_a), .frame_start(fs_a), .field(fld_a), .active(act_a), .line_num(ln_a)
    );

    bt656_pattern_gen u_full_b (
        .bt_clock(clk), .reset(reset_f), .enable(enable_f), .pattern_sel(pat_b),
        .bt_data(bt_b), .frame_start(fs_b), .field(fld_b), .active(act_b), .line_num(ln_b)
    );

    bt656_pattern_gen #(
        .ACTIVE_SAMPLES(8), .BLANK_SAMPLES(4), .FRAME_LINES(625), .BAR_PIXELS(1)
    ) u_small (
        .bt_clock(clk), .reset(reset_s), .enable(enable_s), .pattern_sel(pat_s),
        .bt_data(bt_s), .frame_start(fs_s), .field(fld_s), .active(act_s), .line_num(ln_s)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] trs_xy(input logic f, input logic v, input logic h);
        trs_xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic line_f(input int l);
        line_f = (l >= 313);
    endfunction

    function automatic logic line_v(input int l);
        line_v = (l <= 22) || ((l >= 311) && (l <= 335)) || (l >= 624);
    endfunction

    // Expected byte of a line whose active region carries blanking fill.
    function automatic logic [7:0] exp_vline(input int n, input int sav,
                                             input logic [7:0] eav_xy, input logic [7:0] sav_xy);
        if ((n == 0) || (n == sav))                                   exp_vline = 8'hFF;
        else if ((n == 1) || (n == 2) || (n == sav + 1) || (n == sav + 2)) exp_vline = 8'h00;
        else if (n == 3)                                              exp_vline = eav_xy;
        else if (n == sav + 3)                                        exp_vline = sav_xy;
        else                                                          exp_vline = (n % 2 == 1) ? 8'h10 : 8'h80;
    endfunction

    // Small instance, pattern 2 with 1-pixel bars: W, Yl, Cy, G as Cb Y Cr Y ...
    logic [7:0] bars_small [0:7];
    initial begin
        bars_small[0] = 8'h80; bars_small[1] = 8'hB4;
        bars_small[2] = 8'h8E; bars_small[3] = 8'hA2;
        bars_small[4] = 8'h9C; bars_small[5] = 8'h83;
        bars_small[6] = 8'h3A; bars_small[7] = 8'h70;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_f = 1'b1; enable_f = 1'b0; pat_a = 2'd2; pat_b = 2'd1;
        reset_s = 1'b1; enable_s = 1'b0; pat_s = 2'd2;
        fork
            begin : full_branch
                int err_l1, err_fs, err_chroma, err_idle;
                logic [7:0] cap_a [0:LINE_F-1];
                logic [7:0] cap_b [0:LINE_F-1];
                logic       cap_act [0:LINE_F-1];
                logic [9:0] ln23;
                logic       fld23;
                logic [31:0] word;
                err_l1 = 0; err_fs = 0; err_chroma = 0; err_idle = 0;
                ln23 = 10'd0; fld23 = 1'b1;
                repeat (3) @(negedge clk);
                check_eq("rst_data", 32'(bt_a), 32'h80);
                check_eq("rst_line", 32'(ln_a), 32'd1);
                check_eq("rst_fs", 32'(fs_a), 32'd0);
                check_eq("rst_active", 32'(act_a), 32'd0);
                check_eq("rst_field", 32'(fld_a), 32'd0);
                reset_f = 1'b0;
                @(negedge clk);
                check_eq("idle_first", 32'(bt_a), 32'h10);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if ((bt_a !== 8'h80) && (bt_a !== 8'h10)) err_idle++;
                    if (fs_a !== 1'b0) err_idle++;
                end
                check_eq("idle_fill", 32'(err_idle), 32'd0);
                enable_f = 1'b1;
                for (int l = 1; l <= 23; l++) begin
                    for (int n = 0; n < LINE_F; n++) begin
                        @(negedge clk);
                        if (l == 1) begin
                            if (bt_a !== exp_vline(n, SAV_F, 8'hB6, 8'hAB)) err_l1++;
                            if (act_a !== 1'b0) err_l1++;
                        end
                        if (fs_a !== ((l == 1) && (n == 0))) err_fs++;
                        if (l == 23) begin
                            cap_a[n]   = bt_a;
                            cap_b[n]   = bt_b;
                            cap_act[n] = act_a;
                            if (n == 0) begin
                                ln23  = ln_a;
                                fld23 = fld_a;
                            end
                        end
                    end
                end
                check_eq("line1_bytes", 32'(err_l1), 32'd0);
                check_eq("frame_start_pulse", 32'(err_fs), 32'd0);
                check_eq("l23_line_num", 32'(ln23), 32'd23);
                check_eq("l23_field", 32'(fld23), 32'd0);
                check_eq("l23_eav", {cap_a[0], cap_a[1], cap_a[2], cap_a[3]}, 32'hFF00009D);
                check_eq("l23_sav", {cap_a[284], cap_a[285], cap_a[286], cap_a[287]}, 32'hFF000080);
                check_eq("l23_act_pre", 32'(cap_act[287]), 32'd0);
                check_eq("l23_act_on", 32'(cap_act[288]), 32'd1);
                check_eq("bars_px0", {cap_a[288], cap_a[289], cap_a[290], cap_a[291]}, 32'h80B480B4);
                check_eq("bars_px90", {cap_a[468], cap_a[469], cap_a[470], cap_a[471]}, 32'h2CA28EA2);
                check_eq("bars_px630", {cap_a[1548], cap_a[1549], cap_a[1550], cap_a[1551]}, 32'h80108010);
                check_eq("ramp_px0", 32'(cap_b[289]), 32'h10);
                check_eq("ramp_px4", 32'(cap_b[297]), 32'h11);
                check_eq("ramp_px719", 32'(cap_b[1727]), 32'hC3);
                for (int k = 0; k < 1440; k += 2) begin
                    if (cap_b[288 + k] !== 8'h80) err_chroma++;
                end
                check_eq("ramp_chroma", 32'(err_chroma), 32'd0);
                // Line 24 up to h=286, the second zero of SAV, then reset.
                for (int n = 0; n <= 286; n++) @(negedge clk);
                check_eq("pre_rst_byte", 32'(bt_a), 32'h00);
                check_eq("pre_rst_line", 32'(ln_a), 32'd24);
                #2 reset_f = 1'b1;
                #1;
                check_eq("async_rst_data", 32'(bt_a), 32'h80);
                check_eq("async_rst_line", 32'(ln_a), 32'd1);
                @(negedge clk);
                reset_f = 1'b0;
                word = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    word = {word[23:0], bt_a};
                    if (i == 0) check_eq("post_rst_fs", 32'(fs_a), 32'd1);
                end
                check_eq("post_rst_eav", word, 32'hFF0000B6);
            end
            begin : small_branch
                int err_line, err_field, err_fs, err_byte, err_act, bad_val;
                int act_lines, act_bytes, err_idle, ff_idle;
                logic [7:0] eav [1:625];
                logic [7:0] sav [1:625];
                logic       act_ln [1:625];
                logic [7:0] expb, prev;
                logic [31:0] word;
                err_line = 0; err_field = 0; err_fs = 0; err_byte = 0; err_act = 0;
                bad_val = 0; act_lines = 0; act_bytes = 0; err_idle = 0; ff_idle = 0;
                repeat (3) @(negedge clk);
                reset_s  = 1'b0;
                enable_s = 1'b1;
                // Frame 1: bars; pattern_sel changes mid-frame and must not take effect.
                for (int l = 1; l <= 625; l++) begin
                    act_ln[l] = 1'b0;
                    for (int n = 0; n < LINE_S; n++) begin
                        @(negedge clk);
                        if ((l == 100) && (n == 0)) pat_s = 2'd3;
                        if (ln_s !== 10'(l)) err_line++;
                        if (fld_s !== line_f(l)) err_field++;
                        if (fs_s !== ((l == 1) && (n == 0))) err_fs++;
                        if (n == 3) eav[l] = bt_s;
                        if (n == SAV_S + 3) sav[l] = bt_s;
                        if (act_s === 1'b1) begin
                            act_ln[l] = 1'b1;
                            act_bytes++;
                        end
                        if ((n < ACT_S) || line_v(l)) begin
                            expb = exp_vline(n, SAV_S, trs_xy(line_f(l), line_v(l), 1'b1),
                                             trs_xy(line_f(l), line_v(l), 1'b0));
                            if (act_s !== 1'b0) err_act++;
                        end else begin
                            expb = bars_small[n - ACT_S];
                            if (act_s !== 1'b1) err_act++;
                            if ((bt_s === 8'h00) || (bt_s === 8'hFF)) bad_val++;
                        end
                        if (bt_s !== expb) err_byte++;
                    end
                    if (act_ln[l]) act_lines++;
                end
                check_eq("scan_line_num", 32'(err_line), 32'd0);
                check_eq("scan_field", 32'(err_field), 32'd0);
                check_eq("scan_frame_start", 32'(err_fs), 32'd0);
                check_eq("scan_bytes", 32'(err_byte), 32'd0);
                check_eq("scan_active_flag", 32'(err_act), 32'd0);
                check_eq("scan_no_00_ff", 32'(bad_val), 32'd0);
                check_eq("active_lines", 32'(act_lines), 32'd576);
                check_eq("active_bytes", 32'(act_bytes), 32'd4608);
                check_eq("xy_l1_eav", 32'(eav[1]), 32'hB6);
                check_eq("xy_l1_sav", 32'(sav[1]), 32'hAB);
                check_eq("xy_l23_sav", 32'(sav[23]), 32'h80);
                check_eq("xy_l23_eav", 32'(eav[23]), 32'h9D);
                check_eq("xy_l313_eav", 32'(eav[313]), 32'hF1);
                check_eq("xy_l336_sav", 32'(sav[336]), 32'hC7);
                check_eq("xy_l624_sav", 32'(sav[624]), 32'hEC);
                check_eq("act_edges",
                         {24'd0, act_ln[22], act_ln[23], act_ln[310], act_ln[311],
                          act_ln[335], act_ln[336], act_ln[623], act_ln[624]},
                         32'b01100110);
                // Frame 2: checkerboard; enable drops at line 100 and returns on the last cycle.
                for (int l = 1; l <= 625; l++) begin
                    for (int n = 0; n < LINE_S; n++) begin
                        @(negedge clk);
                        if ((l == 1) && (n == 0)) check_eq("f2_no_gap", {23'd0, fs_s, bt_s}, 32'h1FF);
                        if ((l == 23) && (n == ACT_S)) check_eq("ckr_l23_cb", 32'(bt_s), 32'h80);
                        if ((l == 23) && (n == ACT_S + 1)) check_eq("ckr_l23_y", 32'(bt_s), 32'h10);
                        if ((l == 39) && (n == ACT_S + 1)) check_eq("ckr_l39_y", 32'(bt_s), 32'hEB);
                        if ((l == 55) && (n == ACT_S + 7)) check_eq("ckr_l55_y", 32'(bt_s), 32'h10);
                        if ((l == 100) && (n == 0)) enable_s = 1'b0;
                        if ((l == 625) && (n == LINE_S - 2)) enable_s = 1'b1;
                    end
                end
                // Frame 3: follows with no gap; enable drops at line 100 and stays low.
                for (int l = 1; l <= 625; l++) begin
                    for (int n = 0; n < LINE_S; n++) begin
                        @(negedge clk);
                        if ((l == 1) && (n == 0)) check_eq("f3_no_gap", {23'd0, fs_s, bt_s}, 32'h1FF);
                        if ((l == 100) && (n == 0)) enable_s = 1'b0;
                    end
                end
                check_eq("f3_last_line", 32'(ln_s), 32'd625);
                prev = bt_s;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (bt_s === 8'hFF) ff_idle++;
                    if ((bt_s !== 8'h80) && (bt_s !== 8'h10)) err_idle++;
                    if (bt_s === prev) err_idle++;
                    if ((fs_s !== 1'b0) || (act_s !== 1'b0) || (fld_s !== 1'b0)) err_idle++;
                    if (ln_s !== 10'd1) err_idle++;
                    prev = bt_s;
                end
                check_eq("idle_no_ff", 32'(ff_idle), 32'd0);
                check_eq("idle_pattern", 32'(err_idle), 32'd0);
                enable_s = 1'b1;
                word = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    word = {word[23:0], bt_s};
                    if (i == 0) check_eq("reenable_fs", {22'd0, ln_s}, 32'd1);
                    if (i == 0) check_eq("reenable_pulse", 32'(fs_s), 32'd1);
                end
                check_eq("reenable_eav", word, 32'hFF0000B6);
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
